bcd_seq_ctrl: RTL and testbench
===============================

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 The block SHALL have parameter IN_W, default 13, giving the binary input width; legal range is 1..13.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the requester presents a value on num.
REQ-005 The block SHALL have port num, input, IN_W bits: the unsigned binary value to convert.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a new value.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the BCD digits are final.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have ports Thousands, Hundreds, Tens and Ones, output, 4 bits each: the BCD result digits.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 The state encoding and any unused encodings SHALL recover to IDLE on the next clock edge.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 out_valid SHALL be 1 only in DONE.
REQ-015 busy SHALL equal the inverse of (state == IDLE).
REQ-016 An input handshake SHALL occur on an edge where in_valid and in_ready are both 1; num is sampled only at that edge.
REQ-017 On the input handshake edge, the block SHALL load num into an internal IN_W-bit shift register, clear all four digits to 0, load the bit counter with IN_W, and enter SHIFT.
REQ-018 Each SHIFT cycle SHALL first add 3 (mod 16) to every digit that is >= 5.
REQ-019 Each SHIFT cycle SHALL then shift the concatenation {Thousands, Hundreds, Tens, Ones, shiftreg} left by one, MSB of shiftreg into Ones[0], zero into shiftreg LSB, and decrement the counter.
REQ-020 When the counter reaches 0 after the last shift, the FSM SHALL enter DONE; the transition occurs exactly IN_W cycles after the handshake edge (IN_W=13: out_valid rises 13 edges after acceptance).
REQ-021 In DONE, the digits SHALL hold constant until an output handshake (out_valid and out_ready) occurs, on which the FSM returns to IDLE.
REQ-022 Digits SHALL remain stable through IDLE until the next input handshake clears them.
REQ-023 The input handshake SHALL NOT be possible on the same edge as the output handshake; a new value is accepted no earlier than the cycle after the return to IDLE (minimum period IN_W+2 cycles).
REQ-024 in_valid asserted during SHIFT or DONE SHALL be ignored and SHALL NOT corrupt the conversion.
REQ-025 Changes on num outside the handshake edge SHALL have no effect.
REQ-026 For IN_W=13, the maximum input 8191 SHALL yield 8,1,9,1; no digit ever exceeds 9 in DONE.
REQ-027 out_ready held high permanently SHALL cause DONE to last exactly one cycle.

Reset
REQ-028 Asserting rst_n=0 SHALL, immediately and asynchronously, force state=IDLE, counter=0, shiftreg=0, and all digits=0.
REQ-029 During reset, outputs SHALL be in_ready=1, out_valid=0 and busy=0.
REQ-030 Reset asserted mid-SHIFT or in DONE SHALL abort the conversion with no output handshake.
REQ-031 The first input handshake SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 The bench SHALL cover: num=0, out_ready=1 -> out_valid high 13 cycles after accept, digits 0,0,0,0, DONE lasts 1 cycle.
REQ-033 The bench SHALL cover: num=8191 -> 8,1,9,1; num=255 -> 0,2,5,5; num=1000 -> 1,0,0,0.
REQ-034 The bench SHALL cover: out_ready=0 for 20 cycles after out_valid -> out_valid and digits held; in_valid pulses ignored; release -> IDLE next edge.
REQ-035 The bench SHALL cover: rst_n pulsed low at cycle 6 of SHIFT -> digits 0, in_ready=1 immediately; a new num=42 then converts to 0,0,4,2.
REQ-036 The bench SHALL cover: in_valid held high with values 9,10,99 back-to-back -> each accepted exactly once, spaced 15 cycles apart, results 0009, 0010, 0099.
REQ-037 The bench SHALL cover: IN_W=4, num=15 -> out_valid 4 cycles after accept, digits 0,0,1,5.

Source files
------------

// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
module bcd_seq_ctrl #(
  parameter int IN_W = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [IN_W-1:0] num,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      Thousands,
  output logic [3:0]      Hundreds,
  output logic [3:0]      Tens,
  output logic [3:0]      Ones,
  output logic            busy
);
  localparam int CW = $clog2(IN_W + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [IN_W-1:0] sr_q;
  logic [15:0]     bcd_q, adj_d, bcd_d;
  always_comb begin
    adj_d = '0;
    for (int i = 0; i < 4; i++)
      adj_d[4*i+:4] = (bcd_q[4*i+:4] >= 4'd5) ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    bcd_d = {adj_d[14:0], sr_q[IN_W-1]};
  end
  // Unused encodings fall into default and recover to IDLE on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bcd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sr_q    <= num;
          bcd_q   <= '0;
          cnt_q   <= CW'(IN_W);
          state_q <= SHIFT;
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          sr_q  <= sr_q << 1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign {Thousands, Hundreds, Tens, Ones} = bcd_q;
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// tb_bcd_seq_ctrl: directed, table-driven checks of the 13-bit and 4-bit converters.
module tb_bcd_seq_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, out_ready = 0, in_ready, out_valid, busy;
  logic [12:0] num = '0;
  logic [3:0]  th, hu, te, on;
  logic        in_valid4 = 0, out_ready4 = 1, in_ready4, out_valid4, busy4;
  logic [3:0]  num4 = '0, th4, hu4, te4, on4;
  int tests = 0, fails = 0;

  bcd_seq_ctrl #(.IN_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .Thousands(th), .Hundreds(hu),
    .Tens(te), .Ones(on), .busy(busy));
  bcd_seq_ctrl #(.IN_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .num(num4), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_ready(out_ready4), .Thousands(th4), .Hundreds(hu4),
    .Tens(te4), .Ones(on4), .busy(busy4));

  always #5 clk = ~clk;

  typedef struct {logic [12:0] n; logic [15:0] d;} vec_t;
  vec_t v[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
  task automatic run_conv(input logic [12:0] n, input logic [15:0] exp, input string nm);
    int lat;
    chk({nm, " in_ready"}, in_ready, 1);
    num = n; in_valid = 1; out_ready = 1;
    @(negedge clk);
    in_valid = 0; num = ~n;
    chk({nm, " busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk({nm, " latency"}, lat, 13);
    chk({nm, " digits"}, {th, hu, te, on}, exp);
    @(negedge clk);
    chk({nm, " done one cycle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int lat, na, nr, k;
    logic prev_rdy;
    logic [12:0] seq_n[3];
    logic [15:0] seq_d[3];
    int acc[3];
    logic [15:0] res[3];
    v[0] = '{13'd0,    16'h0000};
    v[1] = '{13'd8191, 16'h8191};
    v[2] = '{13'd255,  16'h0255};
    v[3] = '{13'd1000, 16'h1000};
    v[4] = '{13'd1234, 16'h1234};
    v[5] = '{13'd4095, 16'h4095};
    v[6] = '{13'd5000, 16'h5000};
    v[7] = '{13'd7,    16'h0007};
    seq_n = '{13'd9, 13'd10, 13'd99};
    seq_d = '{16'h0009, 16'h0010, 16'h0099};

    #1;
    chk("reset outputs", {in_ready, out_valid, busy}, 3'b100);
    chk("reset digits", {th, hu, te, on}, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) run_conv(v[i].n, v[i].d, $sformatf("vec%0d", i));

    // Result held while the consumer stalls; in_valid pulses must be ignored.
    num = 13'd1234; in_valid = 1; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("hold latency", lat, 13);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0]; num = 13'($urandom);
      @(negedge clk);
      chk($sformatf("hold c%0d", i), {out_valid, in_ready, th, hu, te, on}, {2'b10, 16'h1234});
    end
    out_ready = 1; in_valid = 1; num = 13'd77;
    @(negedge clk);
    in_valid = 0;
    chk("release idle", {out_valid, in_ready, busy}, 3'b010);
    chk("release digits", {th, hu, te, on}, 16'h1234);
    @(negedge clk);
    chk("idle stable", {busy, th, hu, te, on}, {1'b0, 16'h1234});

    // Asynchronous reset in the middle of SHIFT.
    num = 13'd8191; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    chk("mid shift busy", busy, 1);
    rst_n = 0;
    #1;
    chk("async reset outputs", {in_ready, out_valid, busy}, 3'b100);
    chk("async reset digits", {th, hu, te, on}, 16'h0000);
    @(negedge clk);
    rst_n = 1;
    run_conv(13'd42, 16'h0042, "after reset");

    // in_valid held high across three back-to-back conversions.
    na = 0; nr = 0; prev_rdy = in_ready;
    in_valid = 1; num = seq_n[0];
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (prev_rdy && busy && na < 3) begin
        acc[na] = k; na++;
        if (na < 3) num = seq_n[na]; else in_valid = 0;
      end
      if (out_valid && nr < 3) begin res[nr] = {th, hu, te, on}; nr++; end
      prev_rdy = in_ready;
    end
    in_valid = 0;
    chk("b2b accepts", na, 3);
    chk("b2b results", nr, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b res%0d", i), res[i], seq_d[i]);
    chk("b2b gap01", acc[1] - acc[0], 15);
    chk("b2b gap12", acc[2] - acc[1], 15);

    // Narrow instance: IN_W=4.
    num4 = 4'd15; in_valid4 = 1;
    @(negedge clk);
    in_valid4 = 0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin @(negedge clk); lat++; end
    chk("w4 latency", lat, 4);
    chk("w4 digits", {th4, hu4, te4, on4}, 16'h0015);
    @(negedge clk);
    chk("w4 idle", {out_valid4, in_ready4}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
